kgp_operand_fetch: RTL

Decode/operand-fetch stage of the KGP-RISC pipeline, directly upstream of the ALU. It accepts one 32-bit instruction per cycle over a valid/ready handshake and reads a 32x32 register file. It issues a registered operand1/operand2/mode/en bundle to the ALU. A scoreboard stalls on pending writes, and the ALU result returns through a writeback port with same-cycle bypass.

---
 rtl/kgp_operand_fetch_if.sv | 39 +++
 rtl/kgp_operand_fetch.sv | 122 ++++++++++++
 2 files changed

// File: rtl/kgp_operand_fetch_if.sv
// rtl/kgp_operand_fetch_if.sv - handshake/bus bundle between instruction source, writeback and ALU
//
// Purpose: groups the instruction handshake, the writeback port and the ALU
// operand bundle of the operand-fetch stage.
// Ports (signals):
//   in_valid/in_ready/in_instr : instruction handshake into the stage
//   wb_en/wb_addr/wb_data      : ALU result writeback
//   operand1/operand2/mode/en  : registered bundle to the ALU
//   out_ready/out_rd           : downstream consume strobe, destination tag
//   illegal                    : one-cycle pulse for a dropped illegal instruction
// Modports: slave = operand-fetch stage, master = driver/monitor side.
interface kgp_operand_fetch_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic            wb_en;
  logic [AW-1:0]   wb_addr;
  logic [XLEN-1:0] wb_data;
  logic [XLEN-1:0] operand1;
  logic [XLEN-1:0] operand2;
  logic [3:0]      mode;
  logic            en;
  logic            out_ready;
  logic [AW-1:0]   out_rd;
  logic            illegal;

  modport slave (
    input  in_valid, in_instr, wb_en, wb_addr, wb_data, out_ready,
    output in_ready, operand1, operand2, mode, en, out_rd, illegal
  );

  modport master (
    output in_valid, in_instr, wb_en, wb_addr, wb_data, out_ready,
    input  in_ready, operand1, operand2, mode, en, out_rd, illegal
  );
endinterface

// File: rtl/kgp_operand_fetch.sv
// rtl/kgp_operand_fetch.sv - KGP-RISC decode/operand-fetch stage with scoreboard and writeback bypass
//
// Purpose: decodes one instruction per cycle, reads a 32x32 register file,
// stalls on pending writes (scoreboard) and issues a registered operand bundle.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : kgp_operand_fetch_if.slave (instruction in, writeback in, ALU bundle out)
module kgp_operand_fetch #(
  parameter int NREGS = 32,
  parameter int XLEN  = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  kgp_operand_fetch_if.slave   bus
);
  // Register index width is tied to the 5-bit instruction fields.
  localparam int AW = 5;

  logic [XLEN-1:0]  rf_q [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;
  logic [XLEN-1:0]  op1_q, op1_d, op2_q, op2_d;
  logic [3:0]       mode_q, mode_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic             en_q, en_d;
  logic             illegal_q, illegal_d;

  // Instruction fields
  logic             f_i;
  logic [3:0]       f_mode;
  logic [AW-1:0]    f_rd, f_rs, f_rt;
  logic [15:0]      f_imm;

  assign f_i    = bus.in_instr[31];
  assign f_mode = bus.in_instr[30:27];
  assign f_rd   = bus.in_instr[26:22];
  assign f_rs   = bus.in_instr[21:17];
  assign f_rt   = bus.in_instr[16:12];
  assign f_imm  = bus.in_instr[15:0];

  logic            legal;
  logic            hit_rs, hit_rt, hit_rd;
  logic            busy_rs, busy_rt, busy_rd;
  logic            hazard, can_adv, in_ready, accept;
  logic [XLEN-1:0] val_rs, val_rt;

  always_comb begin
    legal   = (f_mode <= 4'd10);

    // A writeback landing this cycle on a source both supplies the data and
    // releases the scoreboard for this read. Register 0 never participates.
    hit_rs  = bus.wb_en && (bus.wb_addr == f_rs) && (f_rs != '0);
    hit_rt  = bus.wb_en && (bus.wb_addr == f_rt) && (f_rt != '0);
    hit_rd  = bus.wb_en && (bus.wb_addr == f_rd) && (f_rd != '0);

    busy_rs = busy_q[f_rs] && !hit_rs;
    busy_rt = busy_q[f_rt] && !hit_rt;
    busy_rd = busy_q[f_rd] && !hit_rd;

    val_rs  = (f_rs == '0) ? '0 : (hit_rs ? bus.wb_data : rf_q[f_rs]);
    val_rt  = (f_rt == '0) ? '0 : (hit_rt ? bus.wb_data : rf_q[f_rt]);

    // Illegal instructions never stall; they are simply dropped.
    hazard  = legal && (busy_rs || (!f_i && busy_rt) || busy_rd);
    can_adv = !en_q || bus.out_ready;
    in_ready = can_adv && !hazard;
    accept  = bus.in_valid && in_ready;
  end

  always_comb begin
    op1_d     = op1_q;
    op2_d     = op2_q;
    mode_d    = mode_q;
    rd_d      = rd_q;
    en_d      = en_q && !bus.out_ready;
    illegal_d = accept && !legal;
    busy_d    = busy_q;

    if (accept && legal) begin
      op1_d  = val_rs;
      op2_d  = f_i ? {{(XLEN-16){f_imm[15]}}, f_imm} : val_rt;
      mode_d = f_mode;
      rd_d   = f_rd;
      en_d   = 1'b1;
    end

    // Clear first so a same-cycle set on the same register wins.
    if (bus.wb_en) busy_d[bus.wb_addr] = 1'b0;
    if (accept && legal && (f_rd != '0)) busy_d[f_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
      busy_q    <= '0;
      op1_q     <= '0;
      op2_q     <= '0;
      mode_q    <= '0;
      rd_q      <= '0;
      en_q      <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      if (bus.wb_en && (bus.wb_addr != '0)) rf_q[bus.wb_addr] <= bus.wb_data;
      busy_q    <= busy_d;
      op1_q     <= op1_d;
      op2_q     <= op2_d;
      mode_q    <= mode_d;
      rd_q      <= rd_d;
      en_q      <= en_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.operand1 = op1_q;
  assign bus.operand2 = op2_q;
  assign bus.mode     = mode_q;
  assign bus.out_rd   = rd_q;
  assign bus.en       = en_q;
  assign bus.illegal  = illegal_q;
endmodule
